// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared widths and frame FSM states for the SPI bridge stages
package spi_bridge_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT_END} spi_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  // first flop may go metastable, second hands a settled value to the core
  always_ff @(posedge i_clk) begin
    if (i_rst) {o_q, r_meta} <= 2'b00;
    else {o_q, r_meta} <= {r_meta, i_d};
  end
endmodule

// File: rtl/spi_miso_checker.sv
// spi_miso_checker: deserializes MISO frames and compares them against an expected word
module spi_miso_checker
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample_en,
  input  logic              sel_active,
  input  logic              miso_in,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              mismatch,
  output logic [DATA_W-1:0] diff_bits,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              sticky_err
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  spi_state_e        r_state;
  logic [1:0]        r_sample_pipe;
  logic [1:0]        r_sel_pipe;
  logic              r_sel_prev;
  logic              r_sel_armed;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_exp_word;
  logic              r_exp_ok;
  logic              w_miso_s;
  logic              w_sample_d;
  logic              w_sel_d;
  logic              w_sel_rise;
  logic              w_last;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_diff;
  sync_2ff u_miso_sync (
    .i_clk(CLK),
    .i_rst(RST),
    .i_d  (miso_in),
    .o_q  (w_miso_s)
  );
  assign w_sample_d = r_sample_pipe[1];
  assign w_sel_d    = r_sel_pipe[1];
  assign w_sel_rise = w_sel_d & ~r_sel_prev & r_sel_armed;
  assign w_last     = w_sample_d & (r_bit_cnt == LAST);
  assign w_shifted  = {r_shreg[DATA_W-2:0], w_miso_s};
  assign w_diff     = r_shreg ^ r_exp_word;
  // strobe/select delays matching the synchronizer; armed blocks a fake rise after reset inside a live frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sample_pipe <= '0;
      r_sel_pipe    <= '0;
      r_sel_prev    <= 1'b0;
      r_sel_armed   <= 1'b0;
    end else begin
      r_sample_pipe <= {r_sample_pipe[0], sample_en};
      r_sel_pipe    <= {r_sel_pipe[0], sel_active};
      r_sel_prev    <= w_sel_d;
      r_sel_armed   <= r_sel_armed | ~sel_active;
    end
  end
  // frame FSM: shift bits, compare once per word, keep error statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_exp_word <= '0;
      r_exp_ok   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      mismatch   <= 1'b0;
      diff_bits  <= '0;
      frame_err  <= 1'b0;
      err_count  <= '0;
      sticky_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      mismatch  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sel_rise) begin
            r_bit_cnt  <= '0;
            r_exp_word <= exp_data;
            r_exp_ok   <= exp_valid;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_shreg <= w_shifted;
            r_state <= CHECK;
          end else if (!w_sel_d) begin
            frame_err  <= 1'b1;
            sticky_err <= 1'b1;
            r_shreg    <= '0;
            r_state    <= IDLE;
          end else if (w_sample_d) begin
            r_shreg   <= w_shifted;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          rx_data   <= r_shreg;
          rx_valid  <= 1'b1;
          diff_bits <= r_exp_ok ? w_diff : '0;
          if (r_exp_ok && |w_diff) begin
            mismatch   <= 1'b1;
            sticky_err <= 1'b1;
            err_count  <= &err_count ? err_count : err_count + 1'b1;
          end
          r_state <= WAIT_END;
        end
        WAIT_END: begin
          if (!w_sel_d) r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
